mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester and the data (load/store) requester of the pipeline.
- Serialises the two: one transaction outstanding at a time, data side preferred, with a starvation guard for fetch.
- Routes each response back to the requester that owns it.
- Sits between the IF/MEM stages and the bus bridge.

Parameters:
- MAX_STREAK, 4: maximum consecutive data grants while fetch is waiting; the next grant then goes to fetch. Legal range 1..15.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- inst_req  in  1  fetch request valid
- inst_addr  in  32  fetch address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch response valid
- inst_rdata  out  32  fetch read data
- data_req  in  1  data request valid
- data_wr  in  1  1 = store, 0 = load
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_wstrb  in  4  byte write strobes
- data_addr  in  32  data address
- data_wdata  in  32  store data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  data response valid; also the store ack
- data_rdata  out  32  load data
- mem_req  out  1  downstream request valid
- mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/2/4/32/32  latched attributes of the granted request
- mem_addr_ok  in  1  downstream accepted the request
- mem_data_ok  in  1  downstream response valid
- mem_rdata  in  32  downstream read data

Behaviour:
- Clock and reset: clock clk; reset resetn is synchronous and active-low.
- States: IDLE, ADDR, RESP. Two registers:
  - owner: 0 = inst, 1 = data.
  - streak: counter, width ceil(log2(MAX_STREAK+1)).
- Reset (resetn = 0 at a clock edge):
  - state = IDLE, owner = 0, streak = 0.
  - All latched mem_* attribute registers = 0.
  - All outputs 0.
  - Reset mid-transaction abandons the transaction.
  - A late mem_data_ok after reset is ignored, because responses are gated by state == RESP.
- Grant in IDLE is combinational in the cycle of the request:
  - Only data_req: grant data.
  - Only inst_req: grant inst.
  - Both: grant inst if streak == MAX_STREAK, else grant data.
  - The granted side sees *_addr_ok = 1 in that cycle. The other side's addr_ok = 0 and it must hold its request.
  - addr_ok is 0 in ADDR and RESP.
- On grant (clock edge):
  - Latch owner and request attributes. Fetch grants latch wr = 0, size = 2, wstrb = 0, wdata = 0.
  - Go to ADDR.
- Streak update at a grant:
  - Data granted while inst_req = 1: streak + 1, saturating at MAX_STREAK.
  - Data granted while inst_req = 0: streak = 0.
  - Inst granted: streak = 0.
- ADDR state:
  - mem_req = 1 with the latched attributes, held stable until mem_addr_ok.
  - On mem_addr_ok go to RESP.
  - A mem_data_ok arriving in ADDR is ignored.
- RESP state:
  - mem_req = 0.
  - On mem_data_ok, the owner's *_data_ok = 1 in that same cycle (combinational pass-through) with *_rdata = mem_rdata, then go to IDLE.
  - The non-owner's data_ok is never asserted.
  - *_rdata = 0 whenever the corresponding data_ok is 0.
- Throughput:
  - Minimum latency: accept at cycle 0, mem_req at cycle 1, response at cycle 2 if mem_addr_ok comes at cycle 1 and mem_data_ok at cycle 2.
  - Back-to-back transactions: the next grant happens in IDLE, one cycle after data_ok.
  - Peak rate is one transaction per 3 cycles.
- Requests are never dropped or reordered. An unaccepted request may change or withdraw without effect.
- mem_* attributes are registered, so no combinational path from the requesters to the mem_* outputs.

Test Plan:
- Single load: data_req, addr 0x1C000100, size 2. addr_ok at c0, mem_req at c1 with addr 0x1C000100, mem_addr_ok at c1, mem_data_ok at c3 with rdata 0xDEADBEEF. Required: data_data_ok = 1 and data_rdata = 0xDEADBEEF at c3; inst_data_ok stays 0.
- Simultaneous requests: inst 0x1C000000, data store addr 0x100, wstrb 4'b0011, wdata 0x1234. Data granted first (mem_wr = 1, mem_wstrb = 0011). After its data_ok, fetch is granted in the next IDLE cycle and sees inst_data_ok only.
- Starvation guard: MAX_STREAK = 4, data_req and inst_req held continuously. Grant order must be D, D, D, D, I, D, D, D, D, I; streak returns to 0 after each I.
- Downstream stall: mem_addr_ok held low for 5 cycles. mem_req and all mem_* attributes stay constant, and both addr_ok outputs stay 0 throughout.
- Reset mid-RESP: assert resetn = 0 for 1 cycle, then mem_data_ok arrives. No data_ok on either side, state is IDLE, all outputs 0, and the next request is accepted normally.
- Spurious mem_data_ok in IDLE and ADDR: no *_data_ok is produced, and the state is unchanged (IDLE) or stays ADDR.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and downstream memory handshakes around mem_port_arbiter.
// Valid/ready: a request transfers in the cycle where *_req and *_addr_ok are both 1; a response is valid exactly when *_data_ok is 1.
interface mem_port_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  // Arbiter side: serves the two requesters, drives the memory port.
  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata
  );

  // Environment side: the requesters plus the memory/bus bridge.
  modport master (
    output inst_req, inst_addr,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like port between fetch and data requesters: one transaction in flight,
// data preferred, fetch guaranteed a grant after MAX_STREAK consecutive data grants.
module mem_port_arbiter #(
  parameter  int unsigned MAX_STREAK = 4,
  localparam int unsigned SW         = $clog2(MAX_STREAK + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  mem_port_arbiter_if.slave bus,
  output logic [1:0]    dbg_state,
  output logic          dbg_owner,
  output logic [SW-1:0] dbg_streak
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_wr_q, mem_wr_d;
  logic [1:0]    mem_size_q, mem_size_d;
  logic [3:0]    mem_wstrb_q, mem_wstrb_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;

  logic streak_full;
  logic grant_data;
  logic grant_inst;
  logic resp_fire;

  assign streak_full = (streak_q == STREAK_MAX);
  // Data wins unless fetch is waiting and the data streak has hit its limit.
  assign grant_data  = resetn && (state_q == S_IDLE) && bus.data_req
                       && !(bus.inst_req && streak_full);
  assign grant_inst  = resetn && (state_q == S_IDLE) && bus.inst_req && !grant_data;
  // Responses only count while a transaction is waiting for one; stale ones are dropped.
  assign resp_fire   = resetn && (state_q == S_RESP) && bus.mem_data_ok;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_size_d  = mem_size_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant_data) begin
          state_d     = S_ADDR;
          owner_d     = 1'b1;
          mem_req_d   = 1'b1;
          mem_wr_d    = bus.data_wr;
          mem_size_d  = bus.data_size;
          mem_wstrb_d = bus.data_wstrb;
          mem_addr_d  = bus.data_addr;
          mem_wdata_d = bus.data_wdata;
          if (!bus.inst_req) begin
            streak_d = '0;
          end else if (!streak_full) begin
            streak_d = streak_q + SW'(1);
          end
        end else if (grant_inst) begin
          state_d     = S_ADDR;
          owner_d     = 1'b0;
          mem_req_d   = 1'b1;
          mem_wr_d    = 1'b0;
          mem_size_d  = 2'd2;
          mem_wstrb_d = 4'd0;
          mem_addr_d  = bus.inst_addr;
          mem_wdata_d = 32'd0;
          streak_d    = '0;
        end
      end
      S_ADDR: begin
        if (bus.mem_addr_ok) begin
          state_d   = S_RESP;
          mem_req_d = 1'b0;
        end
      end
      S_RESP: begin
        if (bus.mem_data_ok) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_size_q  <= 2'd0;
      mem_wstrb_q <= 4'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_size_q  <= mem_size_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.inst_addr_ok = grant_inst;
  assign bus.data_addr_ok = grant_data;
  assign bus.inst_data_ok = resp_fire && !owner_q;
  assign bus.data_data_ok = resp_fire && owner_q;
  assign bus.inst_rdata   = (resp_fire && !owner_q) ? bus.mem_rdata : 32'd0;
  assign bus.data_rdata   = (resp_fire && owner_q)  ? bus.mem_rdata : 32'd0;

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_size  = mem_size_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign dbg_state  = state_q;
  assign dbg_owner  = owner_q;
  assign dbg_streak = streak_q;

endmodule
